// File: rtl/iir_channel_scheduler_pkg.sv
// rtl/iir_channel_scheduler_pkg.sv - shared types and constants for the channel-multiplexed IIR
// Contents: FSM state encoding, default filter parameters, datapath width helper.
package iir_channel_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MULT,
    S_SUM,
    S_DIV,
    S_WRITE
  } state_t;

  localparam int DEF_Q_IN  = 32;
  localparam int DEF_N_CH  = 8;
  localparam int DEF_CH_W  = 3;
  localparam int DEF_SHIFT = 16;
  localparam int DEF_A2    = -65279;
  localparam int DEF_B1    = 128;
  localparam int DEF_B2    = 128;

  // Two guard bits above the sample plus the fraction bits hold every
  // product and the three-term sum without overflow.
  function automatic int calc_w(input int q_in, input int shift);
    return q_in + shift + 2;
  endfunction

endpackage

// File: rtl/iir_channel_scheduler_if.sv
// rtl/iir_channel_scheduler_if.sv - sample/result bundle between producer and the IIR scheduler
// Inputs to scheduler : data_valid[N_CH], data[N_CH*Q_IN], clear_state, clear_overrun
// Outputs of scheduler: data_out[Q_IN], data_out_channel[CH_W], data_out_valid, busy, overrun[N_CH]
interface iir_channel_scheduler_if #(
  parameter int N_CH = 8,
  parameter int Q_IN = 32,
  parameter int CH_W = 3
);
  logic [N_CH-1:0]      data_valid;
  logic [N_CH*Q_IN-1:0] data;
  logic                 clear_state;
  logic                 clear_overrun;
  logic [Q_IN-1:0]      data_out;
  logic [CH_W-1:0]      data_out_channel;
  logic                 data_out_valid;
  logic                 busy;
  logic [N_CH-1:0]      overrun;

  modport master (
    output data_valid, data, clear_state, clear_overrun,
    input  data_out, data_out_channel, data_out_valid, busy, overrun
  );

  modport slave (
    input  data_valid, data, clear_state, clear_overrun,
    output data_out, data_out_channel, data_out_valid, busy, overrun
  );
endinterface

// File: rtl/iir_rr_arbiter.sv
// rtl/iir_rr_arbiter.sv - combinational round-robin next-grant selector
// i_pending[N_CH] : channels waiting for service
// i_last_grant    : channel served most recently
// o_any           : at least one channel pending
// o_grant         : first pending channel after i_last_grant, wrapping modulo N_CH
module iir_rr_arbiter #(
  parameter int N_CH = 8,
  parameter int CH_W = 3
) (
  input  logic [N_CH-1:0] i_pending,
  input  logic [CH_W-1:0] i_last_grant,
  output logic            o_any,
  output logic [CH_W-1:0] o_grant
);

  function automatic logic [CH_W-1:0] wrap_idx(input logic [CH_W-1:0] base, input int off);
    int s;
    s = (int'(base) + off) % N_CH;
    return CH_W'(s);
  endfunction

  // Scan from farthest to nearest so the nearest pending channel is the
  // last one written and therefore wins.
  always_comb begin
    o_any   = |i_pending;
    o_grant = i_last_grant;
    for (int i = N_CH; i >= 1; i--) begin
      if (i_pending[wrap_idx(i_last_grant, i)]) o_grant = wrap_idx(i_last_grant, i);
    end
  end

endmodule

// File: rtl/iir_channel_scheduler.sv
// rtl/iir_channel_scheduler.sv - one first-order IIR datapath shared round-robin across N_CH channels
// clock, reset : single clock, synchronous active-high reset
// bus (slave)  : per-channel sample strobes/data in; filtered sample, channel tag,
//                valid strobe, busy and sticky per-channel overrun out
module iir_channel_scheduler
  import iir_channel_scheduler_pkg::*;
#(
  parameter int Q_IN  = DEF_Q_IN,
  parameter int N_CH  = DEF_N_CH,
  parameter int CH_W  = DEF_CH_W,
  parameter int SHIFT = DEF_SHIFT,
  parameter int A2    = DEF_A2,
  parameter int B1    = DEF_B1,
  parameter int B2    = DEF_B2
) (
  input logic              clock,
  input logic              reset,
  iir_channel_scheduler_if.slave bus
);

  localparam int W = calc_w(Q_IN, SHIFT);
  localparam logic signed [W-1:0] C_B1   = W'(B1);
  localparam logic signed [W-1:0] C_B2   = W'(B2);
  localparam logic signed [W-1:0] C_A2   = W'(A2);
  localparam logic signed [W-1:0] C_BIAS = W'((1 << SHIFT) - 1);

  state_t r_state, w_next;

  logic [Q_IN-1:0]        r_buf [N_CH];
  logic [Q_IN-1:0]        r_xs  [N_CH];
  logic [Q_IN-1:0]        r_ys  [N_CH];
  logic [N_CH-1:0]        r_pend, r_overrun, w_new_ovr;
  logic [CH_W-1:0]        r_last, r_ch, w_grant;
  logic                   w_any, w_grant_fire, w_clear_fire;
  logic signed [Q_IN-1:0] r_x, r_x1, r_y1;
  logic signed [W-1:0]    r_p0, r_p1, r_p2, r_acc, r_y, w_div;
  logic [Q_IN-1:0]        r_dout;
  logic [CH_W-1:0]        r_dout_ch;
  logic                   r_dout_valid;
  logic                   w_unused_hi;

  iir_rr_arbiter #(.N_CH(N_CH), .CH_W(CH_W)) u_arb (
    .i_pending    (r_pend),
    .i_last_grant (r_last),
    .o_any        (w_any),
    .o_grant      (w_grant)
  );

  // clear_state pre-empts a grant in IDLE and is dropped while busy.
  assign w_clear_fire = (r_state == S_IDLE) && bus.clear_state;
  assign w_grant_fire = (r_state == S_IDLE) && !bus.clear_state && w_any;

  // A strobe on the channel being granted is not an overrun: the old
  // sample leaves for the datapath on this very edge.
  always_comb begin
    w_new_ovr = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_new_ovr[k] = bus.data_valid[k] && r_pend[k] && !(w_grant_fire && (w_grant == CH_W'(k)));
    end
  end

  // Divide truncating toward zero: bias negative sums before the shift.
  assign w_div = r_acc[W-1] ? ((r_acc + C_BIAS) >>> SHIFT) : (r_acc >>> SHIFT);

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_grant_fire) w_next = S_MULT;
      S_MULT:  w_next = S_SUM;
      S_SUM:   w_next = S_DIV;
      S_DIV:   w_next = S_WRITE;
      S_WRITE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Capture buffers, pending bits and sticky overrun.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pend    <= '0;
      r_overrun <= '0;
      for (int k = 0; k < N_CH; k++) r_buf[k] <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (bus.data_valid[k]) begin
          r_buf[k]  <= bus.data[k*Q_IN +: Q_IN];
          r_pend[k] <= 1'b1;
        end else if (w_grant_fire && (w_grant == CH_W'(k))) begin
          r_pend[k] <= 1'b0;
        end
      end
      r_overrun <= (bus.clear_overrun ? '0 : r_overrun) | w_new_ovr;
    end
  end

  // Per-channel filter history; only the granted channel is written back.
  always_ff @(posedge clock) begin
    if (reset || w_clear_fire) begin
      for (int k = 0; k < N_CH; k++) begin
        r_xs[k] <= '0;
        r_ys[k] <= '0;
      end
    end else if (r_state == S_WRITE) begin
      r_xs[r_ch] <= r_x;
      r_ys[r_ch] <= r_y[Q_IN-1:0];
    end
  end

  // Shared datapath, one stage per FSM state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_x          <= '0;
      r_x1         <= '0;
      r_y1         <= '0;
      r_ch         <= '0;
      r_last       <= CH_W'(N_CH - 1);
      r_p0         <= '0;
      r_p1         <= '0;
      r_p2         <= '0;
      r_acc        <= '0;
      r_y          <= '0;
      r_dout       <= '0;
      r_dout_ch    <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_fire) begin
            r_x    <= r_buf[w_grant];
            r_x1   <= r_xs[w_grant];
            r_y1   <= r_ys[w_grant];
            r_ch   <= w_grant;
            r_last <= w_grant;
          end
        end
        S_MULT: begin
          r_p0 <= W'(r_x)  * C_B1;
          r_p1 <= W'(r_x1) * C_B2;
          r_p2 <= W'(r_y1) * C_A2;
        end
        S_SUM:   r_acc <= r_p0 + r_p1 - r_p2;
        S_DIV:   r_y   <= w_div;
        S_WRITE: begin
          r_dout       <= r_y[Q_IN-1:0];
          r_dout_ch    <= r_ch;
          r_dout_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Output wraps to Q_IN bits; the upper quotient bits are intentionally dropped.
  assign w_unused_hi = ^r_y[W-1:Q_IN];

  assign bus.data_out         = r_dout;
  assign bus.data_out_channel = r_dout_ch;
  assign bus.data_out_valid   = r_dout_valid;
  assign bus.busy             = (r_state != S_IDLE);
  assign bus.overrun          = r_overrun;

endmodule

// File: tb/tb_iir_channel_scheduler.sv
// tb/tb_iir_channel_scheduler.sv - self-checking bench for iir_channel_scheduler
module tb_iir_channel_scheduler;
  import iir_channel_scheduler_pkg::*;

  localparam int N_CH  = 8;
  localparam int Q_IN  = 32;
  localparam int CH_W  = 3;
  localparam int SHIFT = 16;
  localparam longint M_A2 = -65279;
  localparam longint M_B1 = 128;
  localparam longint M_B2 = 128;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  iir_channel_scheduler_if #(.N_CH(N_CH), .Q_IN(Q_IN), .CH_W(CH_W)) bus ();

  iir_channel_scheduler #(
    .Q_IN(Q_IN), .N_CH(N_CH), .CH_W(CH_W), .SHIFT(SHIFT),
    .A2(-65279), .B1(128), .B2(128)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int              cyc;
    int              ch;
    logic [Q_IN-1:0] d;
  } out_t;
  out_t oq[$];

  always @(negedge clock)
    if (bus.data_out_valid === 1'b1)
      oq.push_back('{cyc, int'(bus.data_out_channel), bus.data_out});

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int mx [N_CH];
  int my [N_CH];
  int m_last;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < N_CH; k++) begin
      mx[k] = 0;
      my[k] = 0;
    end
  endtask

  task automatic model_reset();
    model_clear();
    m_last = N_CH - 1;
  endtask

  // y[n] = trunc((B1*x + B2*x1 - A2*y1) / 2^SHIFT), stored history wraps to 32 bits.
  function automatic logic [Q_IN-1:0] model_step(input int ch, input int x);
    longint acc, y;
    acc = longint'(x) * M_B1 + longint'(mx[ch]) * M_B2 - longint'(my[ch]) * M_A2;
    y   = acc / (longint'(1) << SHIFT);
    mx[ch] = x;
    my[ch] = int'(y);
    return y[Q_IN-1:0];
  endfunction

  function automatic logic [N_CH*Q_IN-1:0] put(input int ch, input int val);
    logic [N_CH*Q_IN-1:0] v;
    v = '0;
    v[ch*Q_IN +: Q_IN] = val;
    return v;
  endfunction

  task automatic strobe(input logic [N_CH-1:0] mask, input logic [N_CH*Q_IN-1:0] dat, output int scyc);
    @(negedge clock);
    bus.data_valid = mask;
    bus.data       = dat;
    scyc           = cyc;
    @(negedge clock);
    bus.data_valid = '0;
  endtask

  task automatic wait_q(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (oq.size() < n && k < budget) begin
      @(negedge clock);
      k++;
    end
    chk(tag, (oq.size() >= n), 1);
  endtask

  task automatic expect_out(input string tag, input int ch, input logic [Q_IN-1:0] d,
                            input int scyc, input int lat);
    out_t o;
    if (oq.size() == 0) begin
      chk({tag, "_present"}, 0, 1);
    end else begin
      o = oq.pop_front();
      chk({tag, "_ch"}, o.ch, ch);
      chk({tag, "_data"}, o.d, d);
      if (lat >= 0) chk({tag, "_lat"}, o.cyc - scyc, lat);
      m_last = ch;
    end
  endtask

  task automatic pulse_clear_state();
    @(negedge clock);
    bus.clear_state = 1'b1;
    @(negedge clock);
    bus.clear_state = 1'b0;
    model_clear();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int s;
    int base;
    int ch;
    logic [N_CH-1:0] mask;
    logic [N_CH*Q_IN-1:0] dv;
    int vals [N_CH];

    bus.data_valid    = '0;
    bus.data          = '0;
    bus.clear_state   = 1'b0;
    bus.clear_overrun = 1'b0;
    reset             = 1'b1;
    model_reset();
    repeat (3) @(negedge clock);

    chk("rst_data_out", bus.data_out, 0);
    chk("rst_channel", bus.data_out_channel, 0);
    chk("rst_valid", bus.data_out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_overrun", bus.overrun, 0);
    reset = 1'b0;

    // Reset while ch5 is in MULT.
    strobe(8'h20, put(5, 65536), s);
    @(negedge clock);
    chk("mult_busy", bus.busy, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    chk("abort_busy", bus.busy, 0);
    chk("abort_valid", bus.data_out_valid, 0);
    chk("abort_data", bus.data_out, 0);
    chk("abort_overrun", bus.overrun, 0);
    repeat (8) @(negedge clock);
    chk("abort_no_output", oq.size(), 0);
    strobe(8'h20, put(5, 65536), s);
    wait_q("wait_post_abort", 1, 20);
    expect_out("post_abort", 5, model_step(5, 65536), s, 6);

    // Step response on ch0.
    for (int i = 0; i < 3; i++) begin
      strobe(8'h01, put(0, 65536), s);
      wait_q("wait_step", 1, 20);
      expect_out("step", 0, model_step(0, 65536), s, 6);
      repeat (3) @(negedge clock);
    end

    // Negative input on ch2: division truncates toward zero.
    for (int i = 0; i < 2; i++) begin
      strobe(8'h04, put(2, -65536), s);
      wait_q("wait_neg", 1, 20);
      expect_out("neg", 2, model_step(2, -65536), s, 6);
    end

    // All channels at once after reset: served 0..7, 5 cycles apart.
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    dv = '0;
    for (int k = 0; k < N_CH; k++) dv |= put(k, 65536);
    strobe(8'hFF, dv, s);
    wait_q("wait_rr", N_CH, 80);
    for (int k = 0; k < N_CH; k++) expect_out("rr", k, model_step(k, 65536), s, 6 + 5 * k);
    chk("rr_overrun", bus.overrun, 0);

    // Overrun on ch3 while ch0 is in flight; the later sample survives.
    pulse_clear_state();
    strobe(8'h01, put(0, 65536), s);
    strobe(8'h08, put(3, 100), base);
    strobe(8'h08, put(3, 65536), base);
    wait_q("wait_ovr", 2, 40);
    expect_out("ovr_ch0", 0, model_step(0, 65536), s, 6);
    expect_out("ovr_ch3", 3, model_step(3, 65536), base, -1);
    chk("ovr_flag", bus.overrun, 8'h08);
    @(negedge clock);
    bus.clear_overrun = 1'b1;
    @(negedge clock);
    bus.clear_overrun = 1'b0;
    chk("ovr_cleared", bus.overrun, 0);

    // Build ch1 history, clear it, then a fresh sample behaves as from zero.
    for (int i = 0; i < 2; i++) begin
      strobe(8'h02, put(1, 65536), s);
      wait_q("wait_iso", 1, 20);
      expect_out("iso", 1, model_step(1, 65536), s, 6);
    end
    pulse_clear_state();
    strobe(8'h02, put(1, 65536), s);
    wait_q("wait_clr", 1, 20);
    expect_out("clr", 1, model_step(1, 65536), s, 6);

    // Random channel subsets with random data against the model.
    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(0, 5) == 0) pulse_clear_state();
      mask = N_CH'($urandom_range(1, (1 << N_CH) - 1));
      dv   = '0;
      for (int k = 0; k < N_CH; k++) begin
        vals[k] = int'($urandom);
        if (mask[k]) dv |= put(k, vals[k]);
      end
      strobe(mask, dv, s);
      wait_q("wait_rand", $countones(mask), 80);
      base = m_last;
      for (int i = 1; i <= N_CH; i++) begin
        ch = (base + i) % N_CH;
        if (mask[ch]) expect_out("rand", ch, model_step(ch, vals[ch]), s, -1);
      end
    end
    chk("final_overrun", bus.overrun, 0);
    chk("final_queue_empty", oq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
